aes_cipher_iter: RTL

- Iterative AES-128 encryption core: the forward counterpart of the team's decipher path.
- One shared round datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey.
- A round counter FSM steps the datapath over NUM_OF_ROUNDS cycles.
- Consumes the pre-expanded key bus from key expansion and returns the registered ciphertext with a one-cycle done pulse. Sits beside the decipher in the top-level AES wrapper.

---
 rtl/aes_cipher_iter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption core: one shared round datapath stepped by a round counter FSM.
// Optional build macro AES_CIPHER_KEY_LATCH_EN captures the expanded key bus on accept.
module aes_cipher_iter #(
   parameter int unsigned DATA_WIDTH           = 128,
   parameter int unsigned NUM_OF_ROUNDS        = 10,
   parameter int unsigned EXPANSIONED_KEY_SIZE = (NUM_OF_ROUNDS + 1) * DATA_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start_enc,
   input  logic [DATA_WIDTH-1:0]           plaintext,
   input  logic [EXPANSIONED_KEY_SIZE-1:0] round_keys,
   output logic [DATA_WIDTH-1:0]           cyphertext,
   output logic                            done_enc,
   output logic                            busy
);

   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
   localparam int unsigned CNT_W     = $clog2(NUM_OF_ROUNDS + 1);
   localparam int unsigned KSRC_W    = EXPANSIONED_KEY_SIZE - DATA_WIDTH;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic {IDLE, ROUND} fsm_t;

   fsm_t                  fsm_q, fsm_d;
   logic [DATA_WIDTH-1:0] state_q, state_d;
   logic [CNT_W-1:0]      round_cnt, round_cnt_d;
   logic [DATA_WIDTH-1:0] cyphertext_d;
   logic                  done_d, busy_d;

   logic [DATA_WIDTH-1:0] key0, rkey;
   logic [KSRC_W-1:0]     key_src;
   logic [DATA_WIDTH-1:0] sb_out, sr_out, mc_out, round_out;
   logic                  final_round;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // State byte i lives at bits [DATA_WIDTH-1-8*i -: 8]; byte index = row + 4*column.
   function automatic logic [DATA_WIDTH-1:0] sub_bytes(input logic [DATA_WIDTH-1:0] s);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NUM_BYTES; i++)
         r[DATA_WIDTH-1-8*i -: 8] = SBOX[s[DATA_WIDTH-1-8*i -: 8]];
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_rows(input logic [DATA_WIDTH-1:0] s);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned w = 0; w < 4; w++)
            r[DATA_WIDTH-1-8*(w+4*c) -: 8] = s[DATA_WIDTH-1-8*(w+4*((c+w)%4)) -: 8];
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] mix_columns(input logic [DATA_WIDTH-1:0] s);
      logic [DATA_WIDTH-1:0] r;
      logic [7:0] a0, a1, a2, a3;
      r = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[DATA_WIDTH-1-8*(4*c)   -: 8];
         a1 = s[DATA_WIDTH-1-8*(4*c+1) -: 8];
         a2 = s[DATA_WIDTH-1-8*(4*c+2) -: 8];
         a3 = s[DATA_WIDTH-1-8*(4*c+3) -: 8];
         r[DATA_WIDTH-1-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[DATA_WIDTH-1-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[DATA_WIDTH-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[DATA_WIDTH-1-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   assign key0 = round_keys[EXPANSIONED_KEY_SIZE-1 -: DATA_WIDTH];

   // Keys 1..N come from the live bus or from a copy taken on the accepting edge.
`ifdef AES_CIPHER_KEY_LATCH_EN
   logic [KSRC_W-1:0] key_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         key_q <= '0;
      else if (fsm_q == IDLE && start_enc)
         key_q <= round_keys[KSRC_W-1:0];
   end

   assign key_src = key_q;
`else
   assign key_src = round_keys[KSRC_W-1:0];
`endif

   always_comb begin
      rkey = '0;
      for (int unsigned k = 1; k <= NUM_OF_ROUNDS; k++)
         if (round_cnt == CNT_W'(k))
            rkey = key_src[EXPANSIONED_KEY_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH];
   end

   // Shared round: the final round skips MixColumns.
   assign final_round = (round_cnt == CNT_W'(NUM_OF_ROUNDS));
   assign sb_out      = sub_bytes(state_q);
   assign sr_out      = shift_rows(sb_out);
   assign mc_out      = final_round ? sr_out : mix_columns(sr_out);
   assign round_out   = mc_out ^ rkey;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q      <= IDLE;
         state_q    <= '0;
         round_cnt  <= '0;
         cyphertext <= '0;
         done_enc   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         round_cnt  <= round_cnt_d;
         cyphertext <= cyphertext_d;
         done_enc   <= done_d;
         busy       <= busy_d;
      end
   end

   always_comb begin
      fsm_d        = fsm_q;
      state_d      = state_q;
      round_cnt_d  = round_cnt;
      cyphertext_d = cyphertext;
      done_d       = 1'b0;
      busy_d       = busy;
      case (fsm_q)
         IDLE: begin
            if (start_enc) begin
               state_d     = plaintext ^ key0;
               round_cnt_d = CNT_W'(1);
               fsm_d       = ROUND;
               busy_d      = 1'b1;
            end
         end
         ROUND: begin
            state_d = round_out;
            if (final_round) begin
               cyphertext_d = round_out;
               done_d       = 1'b1;
               busy_d       = 1'b0;
               fsm_d        = IDLE;
            end else begin
               round_cnt_d = round_cnt + CNT_W'(1);
            end
         end
         default: begin
            fsm_d  = IDLE;
            busy_d = 1'b0;
         end
      endcase
   end

endmodule
